// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the fetch port, the data port and the memory side
// of mem_arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_code;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_en;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport master (
    output if_req, if_addr, d_req, d_code, d_addr, d_wdata, m_rdata, m_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err, m_en, m_we, m_be, m_addr, m_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_code, d_addr, d_wdata, m_rdata, m_ready,
    output if_ack, if_rdata, d_ack, d_rdata, d_err, m_en, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single word-wide memory, with
// data priority bounded by a starvation counter and sub-word load/store handling.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IF_ACC = 3'd1;
  localparam logic [2:0] D_ACC  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_SW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LB  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd7;

  localparam logic [3:0]  LIMIT_C   = 4'(STARVE_LIMIT);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  function automatic logic misaligned(input logic [3:0] code, input logic [1:0] lo);
    logic bad;
    case (code)
      OP_LW, OP_SW:        bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      default:             bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic is_store(input logic [3:0] code);
    return (code == OP_SW) || (code == OP_SH) || (code == OP_SB);
  endfunction

  function automatic logic [3:0] access_be(input logic [3:0] code, input logic [1:0] lo);
    logic [3:0] be;
    case (code)
      OP_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] code, input logic [31:0] wd);
    logic [31:0] d;
    case (code)
      OP_SH:   d = {wd[15:0], wd[15:0]};
      OP_SB:   d = {4{wd[7:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] code, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] r;
    half = lo[1] ? word[31:16] : word[15:0];
    byt  = word[{lo, 3'b000} +: 8];
    case (code)
      OP_LH:   r = {{16{half[15]}}, half};
      OP_LHU:  r = {16'h0000, half};
      OP_LB:   r = {{24{byt[7]}}, byt};
      OP_LBU:  r = {24'h00_0000, byt};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [2:0] state_r;
  logic [3:0] starve_r;
  logic [3:0] code_r;
  logic [1:0] lo_r;
  logic       d_valid_s;
  logic       d_bad_s;
  logic       grant_if_s;
  logic       grant_d_s;

  // Request qualification and IF/data arbitration, evaluated for use in IDLE.
  always_comb begin
    d_valid_s  = bus.d_req && !bus.d_code[3];
    d_bad_s    = misaligned(bus.d_code, bus.d_addr[1:0]);
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    if (bus.if_req && d_valid_s) begin
      if (starve_r == LIMIT_C) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
    end else if (bus.if_req) begin
      grant_if_s = 1'b1;
    end else if (d_valid_s) begin
      grant_d_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
  end

  // Access FSM with registered memory strobes and registered ack/result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      starve_r     <= 4'd0;
      code_r       <= 4'd0;
      lo_r         <= 2'b00;
      bus.if_ack   <= 1'b0;
      bus.if_rdata <= 32'h0000_0000;
      bus.d_ack    <= 1'b0;
      bus.d_rdata  <= 32'h0000_0000;
      bus.d_err    <= 1'b0;
      bus.m_en     <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_be     <= 4'b0000;
      bus.m_addr   <= 32'h0000_0000;
      bus.m_wdata  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            state_r    <= IF_ACC;
            starve_r   <= 4'd0;
            bus.m_en   <= 1'b1;
            bus.m_we   <= 1'b0;
            bus.m_be   <= 4'b1111;
            bus.m_addr <= bus.if_addr & ADDR_MASK;
          end else if (grant_d_s && d_bad_s) begin
            // Rejected without touching memory or the starvation count.
            state_r     <= ERR;
            bus.d_ack   <= 1'b1;
            bus.d_err   <= 1'b1;
            bus.d_rdata <= 32'h0000_0000;
          end else if (grant_d_s) begin
            state_r <= D_ACC;
            if (bus.if_req && (starve_r != LIMIT_C)) begin
              starve_r <= starve_r + 4'd1;
            end
            code_r      <= bus.d_code;
            lo_r        <= bus.d_addr[1:0];
            bus.m_en    <= 1'b1;
            bus.m_we    <= is_store(bus.d_code);
            bus.m_be    <= access_be(bus.d_code, bus.d_addr[1:0]);
            bus.m_addr  <= bus.d_addr & ADDR_MASK;
            bus.m_wdata <= store_data(bus.d_code, bus.d_wdata);
          end else begin
            state_r <= IDLE;
          end
        end
        IF_ACC: begin
          if (bus.m_ready) begin
            state_r      <= DONE;
            bus.m_en     <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_be     <= 4'b0000;
            bus.if_ack   <= 1'b1;
            bus.if_rdata <= bus.m_rdata;
          end else begin
            state_r <= IF_ACC;
          end
        end
        D_ACC: begin
          if (bus.m_ready) begin
            state_r     <= DONE;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_be    <= 4'b0000;
            bus.d_ack   <= 1'b1;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= is_store(code_r) ? 32'h0000_0000
                                            : load_extract(code_r, lo_r, bus.m_rdata);
          end else begin
            state_r <= D_ACC;
          end
        end
        DONE, ERR: begin
          state_r    <= IDLE;
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          bus.d_err  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          bus.d_err  <= 1'b0;
          bus.m_en   <= 1'b0;
          bus.m_we   <= 1'b0;
          bus.m_be   <= 4'b0000;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants while if_req waits (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch request, held until if_ack.
REQ-005 SHALL have port if_addr, input, 32, fetch byte address; bits [1:0] are ignored.
REQ-006 SHALL have port if_ack, output, 1, one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata, output, 32, fetched word, valid while if_ack=1.
REQ-008 SHALL have port d_req, input, 1, data request, held until d_ack.
REQ-009 SHALL have port d_code, input, 4, memory op code: 0000 lw, 0001 sw, 0010 lh, 0011 lb, 0100 lhu, 0101 lbu, 0110 sh, 0111 sb, 1000 none.
REQ-010 SHALL have port d_addr, input, 32, data byte address.
REQ-011 SHALL have port d_wdata, input, 32, store data, right-aligned for sh/sb.
REQ-012 SHALL have port d_ack, output, 1, one-cycle data completion pulse.
REQ-013 SHALL have port d_rdata, output, 32, extended load result, valid while d_ack=1 and d_err=0.
REQ-014 SHALL have port d_err, output, 1, misalignment flag, valid only with d_ack.
REQ-015 SHALL have port m_en, output, 1, memory access strobe.
REQ-016 SHALL have port m_we, output, 1, memory write enable.
REQ-017 SHALL have port m_be, output, 4, byte enables; bit i selects byte lane i (bits [8i+7:8i]).
REQ-018 SHALL have port m_addr, output, 32, word address with [1:0]=00.
REQ-019 SHALL have port m_wdata, output, 32, lane-replicated store data.
REQ-020 SHALL have port m_rdata, input, 32, memory read word, valid when m_ready=1.
REQ-021 SHALL have port m_ready, input, 1, memory completion, sampled only while m_en=1.

Function
REQ-022 SHALL implement FSM states IDLE, IF_ACC, D_ACC, DONE, ERR; all outputs registered.
REQ-023 SHALL treat d_req with d_code=1000 or 1001..1111 as no request.
REQ-024 In IDLE, only if_req valid -> IF_ACC; only data valid -> D_ACC, or ERR if misaligned; neither -> stay IDLE.
REQ-025 In IDLE, with both valid: data wins unless starve counter == STARVE_LIMIT, in which case IF wins.
REQ-026 Starve counter SHALL increment, saturating at STARVE_LIMIT, on each data grant with if_req=1, and SHALL clear on every IF grant.
REQ-027 Misalignment: lw/sw with addr[1:0]!=00; lh/lhu/sh with addr[0]=1; byte ops are never misaligned.
REQ-028 ERR SHALL last one cycle with d_ack=1, d_err=1, d_rdata=0, m_en=0, then go to IDLE; no memory access occurs and the starve counter is not changed.
REQ-029 IF_ACC SHALL drive m_en=1, m_we=0, m_be=1111, m_addr={if_addr[31:2],00} until m_ready=1.
REQ-030 D_ACC loads (lw/lh/lhu/lb/lbu) SHALL drive m_en=1, m_we=0, m_be=1111.
REQ-031 D_ACC stores SHALL drive m_we=1 with these byte enables: sw 1111; sh 0011 if addr[1]=0, else 1100; sb 0001 shifted left by addr[1:0].
REQ-032 D_ACC store data SHALL be: sw d_wdata; sh {d_wdata[15:0],d_wdata[15:0]}; sb d_wdata[7:0] replicated four times.
REQ-033 Load extraction: halfword at lane addr[1]*16, byte at addr[1:0]*8; lh/lb sign-extend, lhu/lbu zero-extend, lw passes the word.
REQ-034 On m_ready=1 in IF_ACC/D_ACC: capture the result, deassert m_en/m_we/m_be, and enter DONE next cycle.
REQ-035 DONE SHALL pulse the matching ack for exactly one cycle with rdata valid (stores: d_rdata=0), then go to IDLE; the earliest next grant is the following cycle.
REQ-036 Latency: request seen in IDLE at cycle N gives m_en=1 at N+1; m_ready at cycle M gives ack at M+1.
REQ-037 A req drop mid-access SHALL NOT abort the access; the ack is still issued.
REQ-038 if_rdata and d_rdata SHALL hold their value outside ack cycles; m_en=0 in IDLE, DONE and ERR.

Reset
REQ-039 reset=0 SHALL immediately force IDLE, starve counter 0, and all outputs 0, including mid-access.
REQ-040 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-041 lb, addr 0x103, m_rdata 0x80FF_0000 -> m_be=1111, d_rdata=0xFFFF_FF80, d_ack pulse 1 cycle.
REQ-042 sh, addr 0x0E, d_wdata 0x1234_ABCD -> m_we=1, m_be=1100, m_addr=0x0C, m_wdata=0xABCD_ABCD.
REQ-043 lw, addr 0x06 -> d_ack=1 and d_err=1 next cycle, m_en never asserted.
REQ-044 if_req and d_req (lw) held continuously, STARVE_LIMIT=4, m_ready=1 always -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-045 reset low during D_ACC with m_ready=0 -> m_en=0 and all outputs 0 without waiting for clk; after release, a new request proceeds normally.
REQ-046 lhu, addr 0x02, m_ready delayed 3 cycles, m_rdata 0x8001_0000 -> d_ack 1 cycle after m_ready, d_rdata=0x0000_8001.
